// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between
// requester 0 (instruction fetch) and requester 1 (load/store). The winner's
// command is latched on grant, the port is driven for LAT cycles, and a
// one-cycle done pulse returns the read data to the owner.
//
// Handshake: a requester raises req with a stable addr/we/wdata and holds it
// until its done pulse; it drops req in the cycle after done. The command is
// captured on the IDLE->ACCESS edge, so later changes to the requester's
// inputs (including dropping req) do not affect the running transaction.
// A request still high when IDLE samples it is treated as a new request.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LAT    = 2,
  parameter int PRIO   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic              last_gnt_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              winner;
  logic              start;
  logic              access_end;

  // Arbitration: single requester wins outright; a tie goes to requester 0
  // under fixed priority, otherwise to the one not served last.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      winner = (PRIO == 1) ? 1'b0 : ~last_gnt_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Next-state logic; the ACCESS phase ends when the down-counter hits zero.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    access_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACCESS;
          start   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_DONE;
          access_end = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Access-length down-counter, loaded with LAT-1 on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (start) begin
      cnt_q <= LAT_M1;
    end else if (state_q == ST_ACCESS && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Latch the winner's command; mem_sel only moves on a new grant so the
  // steering mux stays quiet through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      sel_q   <= winner;
      we_q    <= winner ? we1 : we0;
      addr_q  <= winner ? addr1 : addr0;
      wdata_q <= winner ? wdata1 : wdata0;
    end
  end

  // Round-robin history and read-data capture at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      rdata_q    <= '0;
    end else if (access_end) begin
      last_gnt_q <= sel_q;
      if (!we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Output decode from the current phase and the latched owner.
  always_comb begin
    gnt0      = (state_q == ST_ACCESS) && !sel_q;
    gnt1      = (state_q == ST_ACCESS) && sel_q;
    done0     = (state_q == ST_DONE) && !sel_q;
    done1     = (state_q == ST_DONE) && sel_q;
    mem_en    = (state_q == ST_ACCESS);
    mem_we    = (state_q == ST_ACCESS) && we_q;
    busy      = (state_q != ST_IDLE);
    mem_sel   = sel_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    fsm_state = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (LAT=2 round-robin, LAT=4 fixed priority)
// driven by directed scenarios, then random requesters, and compared every
// cycle against a transaction-timeline model of the port.
module tb_mem_port_arbiter;

  localparam int LAT_A  = 2;
  localparam int LAT_B  = 4;
  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  logic       clk;
  logic       rst_n;
  logic       req0 [2];
  logic       req1 [2];
  logic       we0 [2];
  logic       we1 [2];
  logic [7:0] addr0 [2];
  logic [7:0] addr1 [2];
  logic [7:0] wdata0 [2];
  logic [7:0] wdata1 [2];
  logic [7:0] mem_rdata [2];
  logic       gnt0 [2];
  logic       gnt1 [2];
  logic       done0 [2];
  logic       done1 [2];
  logic       mem_sel [2];
  logic       mem_en [2];
  logic       mem_we [2];
  logic       busy [2];
  logic [7:0] mem_addr [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] rdata [2];
  logic [1:0] fsm_state [2];

  int vectors;
  int miscompares;

  // Reference model: owner (-1 = none) and age = cycles since grant
  // (1..LAT is the access window, LAT+1 is the done cycle).
  int         m_owner [2];
  int         m_age [2];
  int         m_last [2];
  int         m_sel [2];
  logic       m_we [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  int         m_w;

  bit in_txn [2][2];
  logic [0:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(LAT_A), .PRIO(PRIO_A)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .req1(req1[0]), .addr0(addr0[0]), .addr1(addr1[0]),
    .we0(we0[0]), .we1(we1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata(rdata[0]), .mem_sel(mem_sel[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .fsm_state(fsm_state[0])
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(LAT_B), .PRIO(PRIO_B)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .req1(req1[1]), .addr0(addr0[1]), .addr1(addr1[1]),
    .we0(we0[1]), .we1(we1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata(rdata[1]), .mem_sel(mem_sel[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .fsm_state(fsm_state[1])
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int prio_of(input int i);
    return (i == 0) ? PRIO_A : PRIO_B;
  endfunction

  // Model update: follows each transaction along its timeline.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_owner[i] = -1; m_age[i] = 0; m_last[i] = 1; m_sel[i] = 0;
        m_we[i] = 1'b0; m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_rdata[i] = 8'h00;
      end else if (m_owner[i] < 0) begin
        if (req0[i] || req1[i]) begin
          if (req0[i] && req1[i]) m_w = (prio_of(i) == 1) ? 0 : 1 - m_last[i];
          else                    m_w = req0[i] ? 0 : 1;
          m_owner[i] = m_w;
          m_age[i]   = 1;
          m_sel[i]   = m_w;
          m_we[i]    = (m_w == 1) ? we1[i] : we0[i];
          m_addr[i]  = (m_w == 1) ? addr1[i] : addr0[i];
          m_wdata[i] = (m_w == 1) ? wdata1[i] : wdata0[i];
        end
      end else if (m_age[i] < lat_of(i)) begin
        m_age[i] = m_age[i] + 1;
      end else if (m_age[i] == lat_of(i)) begin
        if (!m_we[i]) m_rdata[i] = mem_rdata[i];
        m_last[i] = m_owner[i];
        m_age[i]  = m_age[i] + 1;
      end else begin
        m_owner[i] = -1;
      end
    end
  end

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d: got %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_inst(input int i);
    bit acc;
    bit dn;
    acc = (m_owner[i] >= 0) && (m_age[i] <= lat_of(i));
    dn  = (m_owner[i] >= 0) && (m_age[i] == lat_of(i) + 1);
    chk("gnt0", i, gnt0[i], acc && m_owner[i] == 0);
    chk("gnt1", i, gnt1[i], acc && m_owner[i] == 1);
    chk("done0", i, done0[i], dn && m_owner[i] == 0);
    chk("done1", i, done1[i], dn && m_owner[i] == 1);
    chk("mem_en", i, mem_en[i], acc);
    chk("mem_we", i, mem_we[i], acc && m_we[i]);
    chk("busy", i, busy[i], m_owner[i] >= 0);
    chk("mem_sel", i, mem_sel[i], m_sel[i]);
    chk("mem_addr", i, mem_addr[i], m_addr[i]);
    chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
    chk("rdata", i, rdata[i], m_rdata[i]);
    chk("phase", i, fsm_state[i], acc ? 1 : (dn ? 2 : 0));
  endtask

  task automatic tick();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  endtask

  // Random requester behaviour: raise with a fresh command, hold until done,
  // drop after done; occasionally drop early once granted.
  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 8'($urandom);
      for (int r = 0; r < 2; r++) begin
        logic g, d, q;
        g = (r == 0) ? gnt0[i] : gnt1[i];
        d = (r == 0) ? done0[i] : done1[i];
        q = (r == 0) ? req0[i] : req1[i];
        if (d) begin
          q = 1'b0;
          in_txn[i][r] = 1'b0;
        end else if (g) begin
          in_txn[i][r] = 1'b1;
          if (q && $urandom_range(0, 7) == 0) q = 1'b0;
        end else if (!in_txn[i][r] && !q && $urandom_range(0, 3) != 0) begin
          q = 1'b1;
          if (r == 0) begin
            addr0[i] = 8'($urandom); we0[i] = 1'($urandom_range(0, 1)); wdata0[i] = 8'($urandom);
          end else begin
            addr1[i] = 8'($urandom); we1[i] = 1'($urandom_range(0, 1)); wdata1[i] = 8'($urandom);
          end
        end
        if (r == 0) req0[i] = q; else req1[i] = q;
      end
    end
  endtask

  initial begin
    int gcnt, bcnt, dcnt, n0;
    bit rr0, rr1, ok;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0;
      addr0[i] = 0; addr1[i] = 0; wdata0[i] = 0; wdata1[i] = 0; mem_rdata[i] = 0;
      m_owner[i] = -1; m_age[i] = 0; m_last[i] = 1; m_sel[i] = 0;
      m_we[i] = 0; m_addr[i] = 0; m_wdata[i] = 0; m_rdata[i] = 0;
      in_txn[i][0] = 0; in_txn[i][1] = 0;
    end

    // Reset state.
    tick();
    tick();
    chk("rst_busy", 0, busy[0], 0);
    rst_n = 1'b1;

    // Read latency on the LAT=2 arbiter: rdata must be the value present in
    // the last ACCESS cycle only.
    req0[0] = 1; addr0[0] = 8'h3C; we0[0] = 0; mem_rdata[0] = 8'h11;
    gcnt = 0; bcnt = 0; dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      gcnt += int'(gnt0[0]);
      bcnt += int'(busy[0]);
      mem_rdata[0] = (gnt0[0] && gcnt == 2) ? 8'hA5 : 8'h11;
      if (gnt0[0]) begin
        chk("rd_addr", 0, mem_addr[0], 8'h3C);
        chk("rd_sel", 0, mem_sel[0], 0);
        chk("rd_en", 0, mem_en[0], 1);
      end
      if (done0[0]) begin
        dcnt++;
        chk("rd_rdata", 0, rdata[0], 8'hA5);
        req0[0] = 0;
      end
    end
    chk("rd_gnt_cycles", 0, gcnt, 2);
    chk("rd_busy_cycles", 0, bcnt, 3);
    chk("rd_done_count", 0, dcnt, 1);

    // Write path: rdata keeps the earlier read value.
    req1[0] = 1; we1[0] = 1; addr1[0] = 8'h10; wdata1[0] = 8'h5A; mem_rdata[0] = 8'h77;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (gnt1[0]) begin
        chk("wr_we", 0, mem_we[0], 1);
        chk("wr_wdata", 0, mem_wdata[0], 8'h5A);
        chk("wr_sel", 0, mem_sel[0], 1);
      end
      if (done1[0]) begin
        dcnt++;
        chk("wr_rdata_hold", 0, rdata[0], 8'hA5);
        req1[0] = 0;
      end
    end
    chk("wr_done_count", 0, dcnt, 1);
    we1[0] = 0;

    // Round-robin alternation with both requesters re-raising after done.
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    req0[0] = 1; req1[0] = 1; rr0 = 0; rr1 = 0; dcnt = 0;
    for (int c = 0; c < 40 && dcnt < 4; c++) begin
      tick();
      chk("rr_one_gnt", 0, gnt0[0] & gnt1[0], 0);
      if (rr0) begin req0[0] = 1; rr0 = 0; end
      if (rr1) begin req1[0] = 1; rr1 = 0; end
      if (done0[0] || done1[0]) begin
        chk("rr_order", 0, done1[0], exp_q.pop_front());
        dcnt++;
        if (done0[0]) begin req0[0] = 0; rr0 = 1; end
        else begin req1[0] = 0; rr1 = 1; end
      end
    end
    chk("rr_count", 0, dcnt, 4);
    req0[0] = 0; req1[0] = 0;

    // Request drop on the LAT=4 arbiter: access still runs its full length.
    req0[1] = 1; addr0[1] = 8'h42; we0[1] = 0; mem_rdata[1] = 8'h3E;
    gcnt = 0; dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt0[1]) begin
        gcnt++;
        if (gcnt == 2) req0[1] = 0;
      end
      if (done0[1]) dcnt++;
    end
    chk("drop_gnt_cycles", 1, gcnt, 4);
    chk("drop_done_count", 1, dcnt, 1);

    // Fixed priority: requester 0 wins three times, then requester 1.
    exp_q = {1'b0, 1'b0, 1'b0, 1'b1};
    req0[1] = 1; req1[1] = 1; rr0 = 0; dcnt = 0; n0 = 0;
    for (int c = 0; c < 60 && dcnt < 4; c++) begin
      tick();
      if (rr0) begin req0[1] = 1; rr0 = 0; end
      if (done0[1] || done1[1]) begin
        chk("fp_order", 1, done1[1], exp_q.pop_front());
        dcnt++;
        if (done0[1]) begin
          n0++;
          req0[1] = 0;
          rr0 = (n0 < 3);
        end else begin
          req1[1] = 0;
        end
      end
    end
    chk("fp_count", 1, dcnt, 4);

    // Random traffic on both arbiters.
    for (int c = 0; c < 1500; c++) begin
      tick();
      drive_random();
    end

    // Let both arbiters drain.
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; req1[i] = 0;
    end
    ok = 0;
    for (int c = 0; c < 12 && !ok; c++) begin
      tick();
      ok = !busy[0] && !busy[1];
    end
    chk("drain_idle", 0, ok, 1);

    // Asynchronous reset during a requester-1 access.
    req1[1] = 1; addr1[1] = 8'hC3; we1[1] = 1; wdata1[1] = 8'h99;
    ok = 0;
    for (int c = 0; c < 4 && !ok; c++) begin
      tick();
      ok = gnt1[1];
    end
    chk("arst_setup_gnt1", 1, ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check_inst(0);
    check_inst(1);
    chk("arst_gnt1", 1, gnt1[1], 0);
    chk("arst_busy", 1, busy[1], 0);
    chk("arst_en", 1, mem_en[1], 0);
    chk("arst_addr", 1, mem_addr[1], 8'h00);
    chk("arst_wdata", 1, mem_wdata[1], 8'h00);
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1; req1[i] = 1;
    end
    tick();
    chk("arst_no_done1", 1, done1[1], 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt0_a", 0, gnt0[0], 1);
    chk("post_rst_gnt0_b", 1, gnt0[1], 1);
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; req1[i] = 0;
    end
    for (int c = 0; c < 10; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
